instr_fetch_unit: RTL

- Multi-cycle fetch stage directly upstream of the control unit.
- Owns the PC and issues word reads to instruction memory over a req/ready handshake.
- Holds the fetched instruction and drives its opcode field into the control unit's control_signal input.
- Consumes the control unit's registered jump/beq/bne outputs plus the ALU zero flag to select the next PC.

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_if.sv | 12 +
 rtl/instr_fetch_unit_next_pc_calc.sv | 33 +++
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Definitions shared by the instruction fetch unit and the control unit it feeds:
// opcodes, fetch FSM encoding and instruction field positions.
package instr_fetch_unit_pkg;

    localparam logic [5:0] OP_JUMP = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RESOLVE = 2'd3
    } fetch_state_e;

    // Word offset of a branch: sign-extended immediate scaled to bytes.
    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: request and word address out, ready and data back.
interface instr_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection for the fetch unit: jump, taken beq/bne branch, or sequential pc+4.
module next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    input  logic        jump_signal_i,
    input  logic        beq_signal_i,
    input  logic        bne_signal_i,
    input  logic        alu_zero_i,
    output logic [31:0] next_pc_o
);

    logic [31:0]                    branchTarget;
    logic                           branchTaken;
    logic [OPCODE_MSB-OPCODE_LSB:0] unusedOpcode;

    assign unusedOpcode = instr_i[OPCODE_MSB:OPCODE_LSB];
    assign branchTarget = pc_plus4_i + branchOffset(instr_i[IMM_MSB:IMM_LSB]);

    // When beq and bne are both raised, beq alone decides whether the branch is taken.
    assign branchTaken = beq_signal_i ? alu_zero_i : (bne_signal_i & ~alu_zero_i);

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_signal_i) begin
            next_pc_o = {pc_plus4_i[31:28], instr_i[TARGET_MSB:TARGET_LSB], 2'b00};
        end else if (branchTaken) begin
            next_pc_o = branchTarget;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, reads instruction memory and resolves the next PC.
// Define JAL_LINK_EN to add the link_valid_o/link_data_o outputs for JAL writes of r31.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    instr_fetch_unit_if.master imem,
    input  logic               stall_i,
    input  logic               jump_signal_i,
    input  logic               beq_signal_i,
    input  logic               bne_signal_i,
    input  logic               alu_zero_i,
    output logic [31:0]        instr_o,
    output logic               instr_valid_o,
    output logic [5:0]         opcode_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
`ifdef JAL_LINK_EN
    output logic               link_valid_o,
    output logic [31:0]        link_data_o,
`endif
    output logic               fetch_err_o
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [7:0]   waitCnt_q, waitCnt_d;
    logic         fetchErr_q, fetchErr_d;
    logic [31:0]  pcPlus4;
    logic [31:0]  nextPc;

    assign pcPlus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4_i    (pcPlus4),
        .instr_i       (instr_q),
        .jump_signal_i (jump_signal_i),
        .beq_signal_i  (beq_signal_i),
        .bne_signal_i  (bne_signal_i),
        .alu_zero_i    (alu_zero_i),
        .next_pc_o     (nextPc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            waitCnt_q  <= '0;
            fetchErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            waitCnt_q  <= waitCnt_d;
            fetchErr_q <= fetchErr_d;
        end
    end

    // A timed-out fetch falls back to FETCH and re-requests the same pc; the error stays sticky.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        waitCnt_d  = waitCnt_q;
        fetchErr_d = fetchErr_q;
        case (state_q)
            ST_FETCH: begin
                if (imem.ready) begin
                    instr_d   = imem.rdata;
                    waitCnt_d = '0;
                    state_d   = ST_ISSUE;
                end else begin
                    waitCnt_d = 8'd1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.ready) begin
                    instr_d   = imem.rdata;
                    waitCnt_d = '0;
                    state_d   = ST_ISSUE;
                end else if (waitCnt_q >= WAIT_LIMIT) begin
                    fetchErr_d = 1'b1;
                    waitCnt_d  = '0;
                    state_d    = ST_FETCH;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (!stall_i) begin
                    pc_d    = nextPc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // The request is gated by reset so it drops the moment reset asserts.
    assign imem.req      = rst_ni & ((state_q == ST_FETCH) | (state_q == ST_WAIT));
    assign imem.addr     = {pc_q[31:2], 2'b00};
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == ST_ISSUE);
    assign opcode_o      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pcPlus4;
    assign fetch_err_o   = fetchErr_q;

`ifdef JAL_LINK_EN
    assign link_valid_o = (state_q == ST_RESOLVE) & ~stall_i &
                          (instr_q[OPCODE_MSB:OPCODE_LSB] == OP_JAL);
    assign link_data_o  = link_valid_o ? pcPlus4 : 32'd0;
`endif

endmodule
